mod_148_4_6_plca_status: RTL and testbench

//  Synthesizable PLCA status function (Clause 148.4.6) for one PHY.

---
 rtl/mod_148_4_6_plca_status.sv | 151 +++++++++++++++
 tb/tb_mod_148_4_6_plca_status.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_148_4_6_plca_status.sv
// mod_148_4_6_plca_status
//   PLCA status function for one PHY. BEACON indications from the PLCA control path
//   drive a four-state machine (DISABLED / INACTIVE / ACTIVE / HYSTERESIS). The machine
//   reports plca_status to the PLS/RS. A bit-time-counting plca_status_timer ages the
//   link out when no BEACON is seen.
//
// Parameters
//   TIMER_BITS  plca_status_timer duration in bit times
//   CNT_W       timer counter width, 2**CNT_W > TIMER_BITS
//
// Ports
//   clk_i                     system clock
//   reset_i                   asynchronous active-high reset
//   bit_tick_i                one-cycle strobe per bit time; the timer advances only on it
//   plca_en_i                 PLCA enable (aPLCAAdminState)
//   local_node_id_i           local node ID, 0 = coordinator
//   tx_beacon_i               pulse: this node sent a BEACON
//   rx_beacon_i               pulse: a BEACON was received
//   plca_status_o             1 = OK, 0 = FAIL (registered)
//   plca_status_timer_done_o  one-cycle pulse on timer expiry
//   plca_state_o              0 DISABLED, 1 INACTIVE, 2 ACTIVE, 3 HYSTERESIS (registered)
//   plca_fail_count_o         saturating count of HYSTERESIS -> INACTIVE transitions
//                             (present only when PLCA_STATUS_FAILCNT_EN is defined)
module mod_148_4_6_plca_status #(
    parameter int unsigned TIMER_BITS = 130090,
    parameter int unsigned CNT_W      = 18
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       bit_tick_i,
    input  logic       plca_en_i,
    input  logic [7:0] local_node_id_i,
    input  logic       tx_beacon_i,
    input  logic       rx_beacon_i,
    output logic       plca_status_o,
    output logic       plca_status_timer_done_o,
`ifdef PLCA_STATUS_FAILCNT_EN
    output logic [15:0] plca_fail_count_o,
`endif
    output logic [1:0] plca_state_o
);

    typedef enum logic [1:0] {
        StDisabled   = 2'd0,
        StInactive   = 2'd1,
        StActive     = 2'd2,
        StHysteresis = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMER_BITS - 1);

    state_e           state_q, state_d;
    logic             status_q, status_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beacon;
    logic             timer_done;

    // Coordinator watches its own transmitted BEACON, followers the received one.
    assign beacon     = (local_node_id_i == 8'd0) ? tx_beacon_i : rx_beacon_i;
    assign timer_done = run_q && bit_tick_i && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        if (run_q && bit_tick_i) begin
            cnt_d = timer_done ? '0 : cnt_q + CNT_W'(1);
        end
        if (!plca_en_i) begin
            state_d = StDisabled;
            run_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StDisabled: begin
                    state_d = StInactive;
                end
                StInactive: begin
                    if (beacon) begin
                        state_d = StActive;
                        run_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                StActive: begin
                    // Beacon takes priority over a coincident expiry.
                    if (beacon) begin
                        cnt_d = '0;
                    end else if (timer_done) begin
                        state_d = StHysteresis;
                        cnt_d   = '0;
                    end
                end
                StHysteresis: begin
                    if (beacon) begin
                        state_d = StActive;
                        cnt_d   = '0;
                    end else if (timer_done) begin
                        state_d = StInactive;
                        run_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StDisabled;
            endcase
        end
        status_d = (state_d == StActive) || (state_d == StHysteresis);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StDisabled;
            status_q <= 1'b0;
            run_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
        end
    end

    assign plca_status_o            = status_q;
    assign plca_state_o             = state_q;
    assign plca_status_timer_done_o = timer_done;

`ifdef PLCA_STATUS_FAILCNT_EN
    logic [15:0] fail_cnt_q, fail_cnt_d;

    // Survives !plca_en; only reset clears it.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if ((state_q == StHysteresis) && (state_d == StInactive) && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fail_cnt_q <= 16'd0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign plca_fail_count_o = fail_cnt_q;
`endif

endmodule

// File: tb/tb_mod_148_4_6_plca_status.sv
// Directed bench for mod_148_4_6_plca_status with TIMER_BITS = 16.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_mod_148_4_6_plca_status;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_tick;
    logic       plca_en;
    logic [7:0] node_id;
    logic       tx;
    logic       rx;
    logic       status;
    logic       done;
    logic [1:0] state;
`ifdef PLCA_STATUS_FAILCNT_EN
    logic [15:0] fail_count;
`endif

    int n_checks   = 0;
    int n_pass     = 0;
    int tick_div   = 1;
    int tick_phase = 0;

    mod_148_4_6_plca_status #(
        .TIMER_BITS(16),
        .CNT_W     (5)
    ) dut (
        .clk_i                   (clk),
        .reset_i                 (reset),
        .bit_tick_i              (bit_tick),
        .plca_en_i               (plca_en),
        .local_node_id_i         (node_id),
        .tx_beacon_i             (tx),
        .rx_beacon_i             (rx),
        .plca_status_o           (status),
        .plca_status_timer_done_o(done),
`ifdef PLCA_STATUS_FAILCNT_EN
        .plca_fail_count_o       (fail_count),
`endif
        .plca_state_o            (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Advance to the next falling edge and update the bit_tick pattern.
    task automatic cyc();
        @(negedge clk);
        tick_phase = (tick_phase + 1) % tick_div;
        bit_tick   = (tick_phase == 0);
    endtask

    // Step cycles (clearing beacon pulses) until timer_done is seen; n = -1 on timeout.
    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            cyc();
            rx = 1'b0;
            tx = 1'b0;
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; plca_en = 1'b1; node_id = 8'd3; rx = 1'b0; tx = 1'b0; bit_tick = 1'b1;
        cyc(); cyc(); #1;
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (status !== 1'b0) $display("FAIL reset_status: got %0b expected 0", status); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else n_pass++;
`ifdef PLCA_STATUS_FAILCNT_EN
        n_checks++; if (fail_count !== 16'd0) $display("FAIL reset_failcnt: got %0h expected 0", fail_count); else n_pass++;
`endif
        cyc(); reset = 1'b0;
        cyc(); #1;
        n_checks++; if (state !== 2'd1) $display("FAIL release_state: got %0d expected 1", state); else n_pass++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(); #1;
            if (status !== 1'b0 || state !== 2'd1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL idle_status: got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

    task automatic test_expiry();
        int n;
        cyc(); rx = 1'b1;
        cyc(); rx = 1'b0; #1;
        n_checks++; if (state !== 2'd2) $display("FAIL beacon_state: got %0d expected 2", state); else n_pass++;
        n_checks++; if (status !== 1'b1) $display("FAIL beacon_status: got %0b expected 1", status); else n_pass++;
        wait_done(100, n);
        n_checks++; if (n != 15) $display("FAIL first_expiry: got %0d expected 15", n); else n_pass++;
        cyc(); #1;
        n_checks++; if (state !== 2'd3) $display("FAIL hyst_state: got %0d expected 3", state); else n_pass++;
        n_checks++; if (status !== 1'b1) $display("FAIL hyst_status: got %0b expected 1", status); else n_pass++;
        wait_done(100, n);
        n_checks++; if (n != 15) $display("FAIL second_expiry: got %0d expected 15", n); else n_pass++;
        cyc(); #1;
        n_checks++; if (state !== 2'd1) $display("FAIL fail_state: got %0d expected 1", state); else n_pass++;
        n_checks++; if (status !== 1'b0) $display("FAIL fail_status: got %0b expected 0", status); else n_pass++;
    endtask

    task automatic test_coordinator();
        int bad;
        int bad_done;
        node_id = 8'd0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(); rx = (i % 10 == 0); tx = 1'b0; #1;
            if (state !== 2'd1) bad++;
        end
        cyc(); rx = 1'b0; #1;
        n_checks++; if (bad != 0 || state !== 2'd1) $display("FAIL coord_rx_ignored: got %0d bad cycles expected 0", bad); else n_pass++;
        bad = 0; bad_done = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(); tx = (i % 10 == 0); #1;
            if (i >= 1 && state !== 2'd2) bad++;
            if (done) bad_done++;
        end
        n_checks++; if (bad != 0) $display("FAIL coord_active_held: got %0d bad cycles expected 0", bad); else n_pass++;
        n_checks++; if (bad_done != 0) $display("FAIL coord_no_expiry: got %0d pulses expected 0", bad_done); else n_pass++;
        cyc(); tx = 1'b0; plca_en = 1'b0;
        cyc(); plca_en = 1'b1;
        cyc(); #1;
        n_checks++; if (state !== 2'd1) $display("FAIL reenable_state: got %0d expected 1", state); else n_pass++;
        node_id = 8'd3;
    endtask

    task automatic test_beacon_at_expiry();
        int n;
        cyc(); rx = 1'b1;
        wait_done(100, n);
        cyc(); #1;
        n_checks++; if (state !== 2'd3) $display("FAIL b2e_hyst: got %0d expected 3", state); else n_pass++;
        wait_done(100, n);
        rx = 1'b1; // coincides with the expiry edge
        cyc(); rx = 1'b0; #1;
        n_checks++; if (state !== 2'd2) $display("FAIL b2e_state: got %0d expected 2", state); else n_pass++;
        n_checks++; if (status !== 1'b1) $display("FAIL b2e_status: got %0b expected 1", status); else n_pass++;
        wait_done(100, n);
        n_checks++; if (n != 15) $display("FAIL b2e_restart: got %0d expected 15", n); else n_pass++;
        cyc(); #1;
        wait_done(100, n);
        cyc(); #1;
        n_checks++; if (state !== 2'd1) $display("FAIL b2e_final: got %0d expected 1", state); else n_pass++;
    endtask

    task automatic test_slow_tick_and_disable();
        int n;
        tick_div = 4;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bit_tick) break;
        end
        rx = 1'b1;
        wait_done(300, n);
        n_checks++; if (n != 64) $display("FAIL slow_expiry: got %0d expected 64", n); else n_pass++;
        cyc(); rx = 1'b1;
        cyc(); rx = 1'b0; #1;
        n_checks++; if (state !== 2'd2) $display("FAIL slow_reactive: got %0d expected 2", state); else n_pass++;
        cyc(); plca_en = 1'b0;
        cyc(); #1;
        n_checks++; if (state !== 2'd0) $display("FAIL disable_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (status !== 1'b0) $display("FAIL disable_status: got %0b expected 0", status); else n_pass++;
        tick_div = 1;
        plca_en  = 1'b1;
        cyc();
    endtask

    task automatic test_async_reset();
        rx = 1'b1;
        cyc(); rx = 1'b0; #1;
        n_checks++; if (state !== 2'd2) $display("FAIL pre_reset_state: got %0d expected 2", state); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (state !== 2'd0 || status !== 1'b0) $display("FAIL async_reset: got state %0d status %0b expected 0 0", state, status); else n_pass++;
        cyc(); reset = 1'b0;
        cyc(); #1;
        n_checks++; if (state !== 2'd1) $display("FAIL post_reset_state: got %0d expected 1", state); else n_pass++;
    endtask

`ifdef PLCA_STATUS_FAILCNT_EN
    task automatic run_expiry_cycle();
        int n;
        rx = 1'b1;
        wait_done(100, n);
        cyc();
        wait_done(100, n);
        cyc(); #1;
    endtask

    task automatic test_failcnt();
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) run_expiry_cycle();
        n_checks++; if (fail_count !== 16'd3) $display("FAIL failcnt_three: got %0h expected 3", fail_count); else n_pass++;
        cyc();
        force dut.fail_cnt_q = 16'hFFFD;
        #1 release dut.fail_cnt_q;
        for (int i = 0; i < 3; i++) run_expiry_cycle();
        n_checks++; if (fail_count !== 16'hFFFF) $display("FAIL failcnt_saturate: got %0h expected ffff", fail_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_expiry();
        test_coordinator();
        test_beacon_at_expiry();
        test_slow_tick_and_disable();
        test_async_reset();
`ifdef PLCA_STATUS_FAILCNT_EN
        test_failcnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
